// File: rtl/rob_pkg.sv
// ============================================================================
//  Module   : rob_pkg
//  Purpose  : Shared sizes and entry layout for the reorder buffer slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int DATA_W    = 32;
    localparam int NUM_FU    = 3;
    localparam int NUM_PREG  = 1 << PREG_W;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [AREG_W-1:0] dr;
        logic [PREG_W-1:0] dr_p;
        logic [PREG_W-1:0] old_dr_p;
        logic [DATA_W-1:0] value;
    } rob_entry_t;
endpackage

`default_nettype wire

// File: rtl/preg_scoreboard.sv
// ============================================================================
//  Module   : preg_scoreboard
//  Purpose  : Per-physical-register ready vector; alloc clears, FU results set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module preg_scoreboard
    import rob_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr_valid,
    input  logic [PREG_W-1:0]        i_clr_tag,
    input  logic [NUM_FU-1:0]        i_set_valid,
    input  logic [NUM_FU*PREG_W-1:0] i_set_tags,
    output logic [NUM_PREG-1:0]      o_ready
);

    logic [NUM_PREG-1:0] r_ready;
    logic [NUM_PREG-1:0] w_ready_nxt;

    // Clear is applied after the sets so a same-tag alloc wins; p0 is hardwired x0.
    always_comb begin
        w_ready_nxt = r_ready;
        for (int f = 0; f < NUM_FU; f++) begin
            if (i_set_valid[f]) begin
                w_ready_nxt[i_set_tags[f*PREG_W +: PREG_W]] = 1'b1;
            end
        end
        if (i_clr_valid) begin
            w_ready_nxt[i_clr_tag] = 1'b0;
        end
        w_ready_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= '1;
        end else begin
            r_ready <= w_ready_nxt;
        end
    end

    assign o_ready = r_ready;

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : In-order retirement buffer with tag-matched FU completion.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer
    import rob_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid_in,
    input  logic                alloc_has_dest_in,
    input  logic [AREG_W-1:0]   alloc_dr_in,
    input  logic [PREG_W-1:0]   alloc_dr_p_in,
    input  logic [PREG_W-1:0]   alloc_old_dr_p_in,
    output logic                alloc_ready_out,
    output logic [IDX_W-1:0]    alloc_idx_out,
    input  logic                FU0_flag_in,
    input  logic [PREG_W-1:0]   reg_tag_from_FU0_in,
    input  logic [DATA_W-1:0]   reg_value_from_FU0_in,
    input  logic                FU1_flag_in,
    input  logic [PREG_W-1:0]   reg_tag_from_FU1_in,
    input  logic [DATA_W-1:0]   reg_value_from_FU1_in,
    input  logic                FU2_flag_in,
    input  logic [PREG_W-1:0]   reg_tag_from_FU2_in,
    input  logic [DATA_W-1:0]   reg_value_from_FU2_in,
    output logic [NUM_PREG-1:0] preg_ready_out,
    output logic                retire_valid_out,
    output logic [AREG_W-1:0]   retire_dr_out,
    output logic [DATA_W-1:0]   retire_value_out,
    output logic                free_valid_out,
    output logic [PREG_W-1:0]   free_preg_out
);

    localparam logic [IDX_W:0] c_FULL = (IDX_W+1)'(ROB_DEPTH);

    rob_entry_t              r_rob [ROB_DEPTH];
    logic [IDX_W-1:0]        r_head;
    logic [IDX_W-1:0]        r_tail;
    logic [IDX_W:0]          r_count;
    logic                    r_retire_valid;
    logic [AREG_W-1:0]       r_retire_dr;
    logic [DATA_W-1:0]       r_retire_value;
    logic                    r_free_valid;
    logic [PREG_W-1:0]       r_free_preg;

    logic [NUM_FU-1:0]        w_fu_flag;
    logic [NUM_FU*PREG_W-1:0] w_fu_tags;
    logic [NUM_FU*DATA_W-1:0] w_fu_vals;
    logic                     w_alloc_ok;
    logic                     w_retire;
    logic [ROB_DEPTH-1:0]     w_hit;
    logic [DATA_W-1:0]        w_hit_val [ROB_DEPTH];

    assign w_fu_flag = {FU2_flag_in, FU1_flag_in, FU0_flag_in};
    assign w_fu_tags = {reg_tag_from_FU2_in, reg_tag_from_FU1_in, reg_tag_from_FU0_in};
    assign w_fu_vals = {reg_value_from_FU2_in, reg_value_from_FU1_in, reg_value_from_FU0_in};

    assign alloc_ready_out = (r_count != c_FULL);
    assign alloc_idx_out   = r_tail;
    assign w_alloc_ok      = alloc_valid_in && alloc_ready_out;
    // Uses the registered done bit, so completion and retire never share an edge.
    assign w_retire        = (r_count != '0) && r_rob[r_head].valid && r_rob[r_head].done;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            w_hit[i]     = 1'b0;
            w_hit_val[i] = '0;
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_fu_flag[f] && r_rob[i].valid && r_rob[i].has_dest && !r_rob[i].done &&
                    (r_rob[i].dr_p == w_fu_tags[f*PREG_W +: PREG_W])) begin
                    w_hit[i]     = 1'b1;
                    w_hit_val[i] = w_fu_vals[f*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rob[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_retire_valid <= 1'b0;
            r_retire_dr    <= '0;
            r_retire_value <= '0;
            r_free_valid   <= 1'b0;
            r_free_preg    <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (w_hit[i]) begin
                    r_rob[i].done  <= 1'b1;
                    r_rob[i].value <= w_hit_val[i];
                end
            end

            if (w_retire) begin
                r_rob[r_head]  <= '0;
                r_head         <= r_head + IDX_W'(1);
                r_retire_valid <= 1'b1;
                r_retire_dr    <= r_rob[r_head].dr;
                r_retire_value <= r_rob[r_head].value;
                r_free_valid   <= r_rob[r_head].has_dest;
                r_free_preg    <= r_rob[r_head].old_dr_p;
            end else begin
                r_retire_valid <= 1'b0;
                r_free_valid   <= 1'b0;
            end

            if (w_alloc_ok) begin
                r_rob[r_tail] <= '{valid:    1'b1,
                                   done:     ~alloc_has_dest_in,
                                   has_dest: alloc_has_dest_in,
                                   dr:       alloc_dr_in,
                                   dr_p:     alloc_dr_p_in,
                                   old_dr_p: alloc_old_dr_p_in,
                                   value:    '0};
                r_tail        <= r_tail + IDX_W'(1);
            end

            r_count <= r_count + {{IDX_W{1'b0}}, w_alloc_ok} - {{IDX_W{1'b0}}, w_retire};
        end
    end

    preg_scoreboard u_preg_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_clr_valid (w_alloc_ok && alloc_has_dest_in),
        .i_clr_tag   (alloc_dr_p_in),
        .i_set_valid (w_fu_flag),
        .i_set_tags  (w_fu_tags),
        .o_ready     (preg_ready_out)
    );

    assign retire_valid_out = r_retire_valid;
    assign retire_dr_out    = r_retire_dr;
    assign retire_value_out = r_retire_value;
    assign free_valid_out   = r_free_valid;
    assign free_preg_out    = r_free_preg;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Random + directed bench for reorder_buffer with a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reorder_buffer;
    import rob_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                alloc_valid_in;
    logic                alloc_has_dest_in;
    logic [AREG_W-1:0]   alloc_dr_in;
    logic [PREG_W-1:0]   alloc_dr_p_in;
    logic [PREG_W-1:0]   alloc_old_dr_p_in;
    logic                alloc_ready_out;
    logic [IDX_W-1:0]    alloc_idx_out;
    logic                fu_flag [3];
    logic [PREG_W-1:0]   fu_tag  [3];
    logic [DATA_W-1:0]   fu_val  [3];
    logic [NUM_PREG-1:0] preg_ready_out;
    logic                retire_valid_out;
    logic [AREG_W-1:0]   retire_dr_out;
    logic [DATA_W-1:0]   retire_value_out;
    logic                free_valid_out;
    logic [PREG_W-1:0]   free_preg_out;

    reorder_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .alloc_valid_in        (alloc_valid_in),
        .alloc_has_dest_in     (alloc_has_dest_in),
        .alloc_dr_in           (alloc_dr_in),
        .alloc_dr_p_in         (alloc_dr_p_in),
        .alloc_old_dr_p_in     (alloc_old_dr_p_in),
        .alloc_ready_out       (alloc_ready_out),
        .alloc_idx_out         (alloc_idx_out),
        .FU0_flag_in           (fu_flag[0]),
        .reg_tag_from_FU0_in   (fu_tag[0]),
        .reg_value_from_FU0_in (fu_val[0]),
        .FU1_flag_in           (fu_flag[1]),
        .reg_tag_from_FU1_in   (fu_tag[1]),
        .reg_value_from_FU1_in (fu_val[1]),
        .FU2_flag_in           (fu_flag[2]),
        .reg_tag_from_FU2_in   (fu_tag[2]),
        .reg_value_from_FU2_in (fu_val[2]),
        .preg_ready_out        (preg_ready_out),
        .retire_valid_out      (retire_valid_out),
        .retire_dr_out         (retire_dr_out),
        .retire_value_out      (retire_value_out),
        .free_valid_out        (free_valid_out),
        .free_preg_out         (free_preg_out)
    );

    typedef struct {
        logic [4:0]  dr;
        logic [5:0]  dr_p;
        logic [5:0]  old;
        bit          has_dest;
        bit          done;
        logic [31:0] value;
    } m_ent_t;

    typedef struct {
        logic [4:0]  dr;
        logic [31:0] value;
        bit          has_dest;
        logic [5:0]  old;
        int          cyc;
    } exp_t;

    m_ent_t      m_rob [$];
    exp_t        exp_q [$];
    logic [63:0] m_ready = '1;
    int          m_tail  = 0;
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_err   = 0;
    bit          mon_en  = 1'b0;
    logic [5:0]  free_log [$];
    int          ret_cyc_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: program-ordered queue, one retire per edge from the front.
    task automatic model_step();
        int sz;
        bit acc;
        cyc++;
        if (rst) begin
            m_rob.delete();
            m_ready = '1;
            m_tail  = 0;
            return;
        end
        sz  = m_rob.size();
        acc = alloc_valid_in && (sz < 16);
        if (sz > 0 && m_rob[0].done) begin
            exp_q.push_back('{dr: m_rob[0].dr, value: m_rob[0].value,
                              has_dest: m_rob[0].has_dest, old: m_rob[0].old, cyc: cyc});
            void'(m_rob.pop_front());
        end
        for (int f = 0; f < 3; f++) begin
            if (fu_flag[f]) begin
                foreach (m_rob[j]) begin
                    if (m_rob[j].has_dest && !m_rob[j].done && m_rob[j].dr_p == fu_tag[f]) begin
                        m_rob[j].done  = 1'b1;
                        m_rob[j].value = fu_val[f];
                    end
                end
                m_ready[fu_tag[f]] = 1'b1;
            end
        end
        if (acc) begin
            if (alloc_has_dest_in) m_ready[alloc_dr_p_in] = 1'b0;
            m_rob.push_back('{dr: alloc_dr_in, dr_p: alloc_dr_p_in, old: alloc_old_dr_p_in,
                              has_dest: alloc_has_dest_in, done: !alloc_has_dest_in, value: 32'd0});
            m_tail = (m_tail + 1) % 16;
        end
        m_ready[0] = 1'b1;
    endtask

    task automatic monitor_step();
        exp_t e;
        chk("preg_ready", preg_ready_out, m_ready);
        chk("alloc_ready", alloc_ready_out, m_rob.size() < 16);
        chk("alloc_idx", alloc_idx_out, m_tail);
        if (retire_valid_out) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", retire_valid_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("retire_cycle", cyc, e.cyc);
                chk("retire_dr", retire_dr_out, e.dr);
                chk("retire_value", retire_value_out, e.value);
                chk("free_valid", free_valid_out, e.has_dest);
                if (e.has_dest) chk("free_preg", free_preg_out, e.old);
                free_log.push_back(free_preg_out);
                ret_cyc_log.push_back(cyc);
            end
        end else begin
            chk("free_valid_idle", free_valid_out, 1'b0);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("retire_missing", retire_valid_out, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) monitor_step();
    end

    task automatic clr_inputs();
        alloc_valid_in    = 1'b0;
        alloc_has_dest_in = 1'b0;
        alloc_dr_in       = '0;
        alloc_dr_p_in     = '0;
        alloc_old_dr_p_in = '0;
        for (int f = 0; f < 3; f++) begin
            fu_flag[f] = 1'b0;
            fu_tag[f]  = '0;
            fu_val[f]  = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        clr_inputs();
    endtask

    task automatic set_alloc(input bit hd, input logic [4:0] dr, input logic [5:0] drp, input logic [5:0] old);
        alloc_valid_in    = 1'b1;
        alloc_has_dest_in = hd;
        alloc_dr_in       = dr;
        alloc_dr_p_in     = drp;
        alloc_old_dr_p_in = old;
    endtask

    task automatic set_fu(input int f, input logic [5:0] tag, input logic [31:0] val);
        fu_flag[f] = 1'b1;
        fu_tag[f]  = tag;
        fu_val[f]  = val;
    endtask

    function automatic logic [5:0] pick_preg();
        logic [5:0] p;
        bit busy;
        for (int t = 0; t < 200; t++) begin
            p    = 6'($urandom_range(1, 63));
            busy = 1'b0;
            foreach (m_rob[j]) if (m_rob[j].has_dest && m_rob[j].dr_p == p) busy = 1'b1;
            if (!busy) return p;
        end
        return 6'd63;
    endfunction

    task automatic auto_complete(input int pct);
        int f;
        f = 0;
        foreach (m_rob[j]) begin
            if (f < 3 && m_rob[j].has_dest && !m_rob[j].done && ($urandom_range(0, 99) < pct)) begin
                set_fu(f, m_rob[j].dr_p, $urandom);
                f++;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (m_rob.size() == 0 && exp_q.size() == 0) break;
            auto_complete(100);
            tick();
        end
        chk("drain_timeout", m_rob.size() + exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int wraps;
        logic [IDX_W-1:0] prev_idx;

        rst = 1'b1;
        clr_inputs();
        repeat (3) tick();
        chk("rst_preg_ready", preg_ready_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_alloc_ready", alloc_ready_out, 1'b1);
        chk("rst_retire_valid", retire_valid_out, 1'b0);
        chk("rst_free_valid", free_valid_out, 1'b0);
        chk("rst_retire_value", retire_value_out, 32'd0);
        chk("rst_alloc_idx", alloc_idx_out, 4'd0);
        mon_en = 1'b1;
        rst    = 1'b0;

        // Out-of-order completion, in-order retirement.
        free_log.delete();
        set_alloc(1, 5'd5, 6'd33, 6'd1); tick();
        set_alloc(1, 5'd6, 6'd34, 6'd2); tick();
        set_alloc(1, 5'd7, 6'd35, 6'd3); tick();
        chk("rdy_33_35_after_alloc", preg_ready_out[35:33], 3'b000);
        set_fu(0, 6'd35, 32'hA5A5_0035); tick();
        chk("rdy_35_after_complete", preg_ready_out[35], 1'b1);
        chk("no_retire_before_head", retire_valid_out, 1'b0);
        set_fu(1, 6'd33, 32'h1234_0033); tick();
        set_fu(2, 6'd34, 32'hBEEF_0034); tick();
        chk("rdy_33_35_after_complete", preg_ready_out[35:33], 3'b111);
        drain();
        chk("free_log_len", free_log.size(), 3);
        if (free_log.size() == 3) begin
            chk("free_order_0", free_log[0], 6'd1);
            chk("free_order_1", free_log[1], 6'd2);
            chk("free_order_2", free_log[2], 6'd3);
        end

        // Fill to full from a fresh start; extra alloc must be ignored.
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            set_alloc(1, 5'(k), 6'(10 + k), 6'(k)); tick();
        end
        chk("full_alloc_ready", alloc_ready_out, 1'b0);
        set_alloc(1, 5'd31, 6'd26, 6'd9); tick();
        chk("full_ignored_idx", alloc_idx_out, 4'd0);
        chk("full_ignored_ready", alloc_ready_out, 1'b0);
        chk("full_ignored_rdy26", preg_ready_out[26], 1'b1);
        drain();

        // Three-port completion, then same-cycle alloc clear vs FU set.
        ret_cyc_log.delete();
        set_alloc(1, 5'd1, 6'd40, 6'd4); tick();
        set_alloc(1, 5'd2, 6'd41, 6'd5); tick();
        set_alloc(1, 5'd3, 6'd42, 6'd6); tick();
        set_fu(0, 6'd40, 32'h40); set_fu(1, 6'd41, 32'h41); set_fu(2, 6'd42, 32'h42); tick();
        set_alloc(1, 5'd4, 6'd43, 6'd7); set_fu(0, 6'd43, 32'h43); tick();
        chk("alloc_wins_rdy43", preg_ready_out[43], 1'b0);
        repeat (3) tick();
        chk("burst_retire_count", ret_cyc_log.size(), 3);
        if (ret_cyc_log.size() >= 3) begin
            chk("burst_consec_1", ret_cyc_log[1], ret_cyc_log[0] + 1);
            chk("burst_consec_2", ret_cyc_log[2], ret_cyc_log[1] + 1);
        end
        drain();

        // 40 alloc/complete/retire pairs; the index must wrap exactly twice.
        wraps    = 0;
        prev_idx = alloc_idx_out;
        for (int k = 0; k < 40; k++) begin
            logic [5:0] t;
            t = pick_preg();
            if (k > 0 && prev_idx == 4'd15 && alloc_idx_out == 4'd0) wraps++;
            prev_idx = alloc_idx_out;
            set_alloc(1, 5'($urandom), t, 6'($urandom)); tick();
            set_fu($urandom_range(0, 2), t, $urandom); tick();
            tick();
        end
        chk("idx_wraps", wraps, 2);
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 55) begin
                bit hd;
                hd = ($urandom_range(0, 99) < 80);
                set_alloc(hd, 5'($urandom), hd ? pick_preg() : 6'($urandom), 6'($urandom));
            end
            auto_complete(40);
            tick();
        end
        drain();

        // Reset with pending work discards everything silently.
        for (int k = 0; k < 5; k++) begin
            set_alloc(1, 5'(k + 8), 6'(50 + k), 6'(20 + k)); tick();
        end
        chk("pending_before_rst", preg_ready_out[54:50], 5'b00000);
        pulse_reset();
        chk("midrst_preg_ready", preg_ready_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("midrst_alloc_ready", alloc_ready_out, 1'b1);
        chk("midrst_alloc_idx", alloc_idx_out, 4'd0);
        for (int k = 0; k < 3; k++) begin
            chk("midrst_no_retire", retire_valid_out, 1'b0);
            chk("midrst_no_free", free_valid_out, 1'b0);
            tick();
        end
        set_alloc(0, 5'd9, 6'd0, 6'd0); tick();
        tick();
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
